demux8_buf: RTL and testbench

DEMUX8_BUF -- requirements
Module: demux8_buf

---
 rtl/demux8_buf_pkg.sv | 13 +
 rtl/skid_buf2.sv | 77 +++++++
 rtl/demux8_buf.sv | 52 +++++
 tb/tb_demux8_buf.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/demux8_buf_pkg.sv
// Shared constants and state encodings for the 8-way buffered demux.
// Imported by the buffer and the top.
package demux8_buf_pkg;

  localparam int NUM_DEST = 8;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } buf_state_t;

endpackage

// File: rtl/skid_buf2.sv
// Two-entry in-order buffer with a registered ready.
// Head entry reads as zero whenever the buffer is empty.
module skid_buf2
  import demux8_buf_pkg::*;
#(
  parameter int width = 35
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [width-1:0] push_data,
  input  logic             pop,
  output logic             head_valid,
  output logic [width-1:0] head_data
);

  buf_state_t       state;
  logic [width-1:0] tail_q;
  logic             push;
  logic             pop_ok;

  assign push       = push_valid & push_ready;
  assign pop_ok     = pop & (state != ST_EMPTY);
  assign head_valid = (state != ST_EMPTY);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_EMPTY;
      head_data  <= '0;
      tail_q     <= '0;
      push_ready <= 1'b0;
    end else begin
      case (state)
        ST_EMPTY: begin
          push_ready <= 1'b1;
          if (push) begin
            head_data <= push_data;
            state     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (push && pop_ok) begin
            head_data  <= push_data;
            push_ready <= 1'b1;
          end else if (push) begin
            tail_q     <= push_data;
            state      <= ST_FULL;
            push_ready <= 1'b0;
          end else if (pop_ok) begin
            head_data  <= '0;
            state      <= ST_EMPTY;
            push_ready <= 1'b1;
          end else begin
            push_ready <= 1'b1;
          end
        end
        ST_FULL: begin
          // ready is low here, so only a pop can move us
          if (pop_ok) begin
            head_data  <= tail_q;
            state      <= ST_ONE;
            push_ready <= 1'b1;
          end else begin
            push_ready <= 1'b0;
          end
        end
        default: begin
          state      <= ST_EMPTY;
          head_data  <= '0;
          push_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/demux8_buf.sv
// 8-way demux behind a 2-entry in-order buffer.
// Only the head destination's ready can pop the buffer.
module demux8_buf
  import demux8_buf_pkg::*;
#(
  parameter int buswidth = 32,
  parameter int selwidth = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [selwidth-1:0] in_select,
  input  logic [buswidth-1:0] in_data,
  output logic [NUM_DEST-1:0] out_valid,
  input  logic [NUM_DEST-1:0] out_ready,
  output logic [buswidth-1:0] demuxout
);

  localparam int W = selwidth + buswidth;

  logic [W-1:0]        head;
  logic                head_valid;
  logic [selwidth-1:0] head_sel;
  logic                pop;

  assign head_sel = head[W-1 -: selwidth];
  assign demuxout = head[buswidth-1:0];
  assign pop      = head_valid & out_ready[head_sel];

  skid_buf2 #(
    .width(W)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .push_valid(in_valid),
    .push_ready(in_ready),
    .push_data ({in_select, in_data}),
    .pop       (pop),
    .head_valid(head_valid),
    .head_data (head)
  );

  always_comb begin
    out_valid = '0;
    for (int k = 0; k < NUM_DEST; k++) begin
      if (head_valid && head_sel == selwidth'(k))
        out_valid[k] = 1'b1;
    end
  end

endmodule

// File: tb/tb_demux8_buf.sv
// Directed and random checks of demux8_buf against a queue model.
module tb_demux8_buf;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_select = '0;
  logic [31:0] in_data = '0;
  logic [7:0]  out_valid;
  logic [7:0]  out_ready = '0;
  logic [31:0] demuxout;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] data;
  } ent_t;

  ent_t q[$];
  logic exp_ready = 1'b0;
  bit   model_live = 1'b0;

  demux8_buf dut (
    .clk      (clk),
    .reset    (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_select(in_select),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .demuxout (demuxout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
               $time);
    end
  endtask

  // queue model: capacity 2, head is q[0]
  always @(posedge clk) begin
    bit push;
    bit pop;
    pop  = (q.size() > 0) && out_ready[q[0].sel];
    push = in_valid && exp_ready;
    if (rst) begin
      q.delete();
      exp_ready <= 1'b0;
    end else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back('{sel: in_select, data: in_data});
      exp_ready <= (q.size() < 2);
    end
    model_live <= 1'b1;
  end

  always @(negedge clk) begin
    logic [7:0]  ev;
    logic [31:0] ed;
    if (model_live) begin
      ev = '0;
      ed = '0;
      if (q.size() > 0) begin
        ev[q[0].sel] = 1'b1;
        ed = q[0].data;
      end
      chk("model_out_valid", 64'(out_valid), 64'(ev));
      chk("model_demuxout", 64'(demuxout), 64'(ed));
      chk("model_in_ready", 64'(in_ready), 64'(exp_ready));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] s,
                       input logic [31:0] d);
    in_valid  = v;
    in_select = s;
    in_data   = d;
  endtask

  initial begin
    // reset held with a word offered
    rst = 1'b1;
    drive(1'b1, 3'd4, 32'hCAFE0000);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'h00);
      chk("rst_demuxout", 64'(demuxout), 64'd0);
    end
    rst = 1'b0;
    drive(1'b0, 3'd0, 32'd0);
    cyc();
    chk("post_rst_ready", 64'(in_ready), 64'd1);
    chk("post_rst_empty", 64'(out_valid), 64'h00);

    // single word
    out_ready = 8'hFF;
    drive(1'b1, 3'd5, 32'hDEADBEEF);
    cyc();
    drive(1'b0, 3'd0, 32'd0);
    chk("single_valid", 64'(out_valid), 64'h20);
    chk("single_data", 64'(demuxout), 64'hDEADBEEF);
    cyc();
    chk("single_gone", 64'(out_valid), 64'h00);
    chk("single_zero", 64'(demuxout), 64'd0);

    // backpressure
    out_ready = 8'h00;
    drive(1'b1, 3'd2, 32'h11);
    cyc();
    drive(1'b1, 3'd7, 32'h22);
    cyc();
    chk("bp_full_ready", 64'(in_ready), 64'd0);
    chk("bp_full_valid", 64'(out_valid), 64'h04);
    chk("bp_full_data", 64'(demuxout), 64'h11);
    drive(1'b1, 3'd0, 32'h33);
    cyc();
    drive(1'b0, 3'd0, 32'd0);
    chk("bp_third_valid", 64'(out_valid), 64'h04);
    chk("bp_third_ready", 64'(in_ready), 64'd0);
    out_ready = 8'h04;
    cyc();
    chk("bp_second_valid", 64'(out_valid), 64'h80);
    chk("bp_second_data", 64'(demuxout), 64'h22);
    chk("bp_ready_back", 64'(in_ready), 64'd1);
    out_ready = 8'h80;
    cyc();
    chk("bp_drained", 64'(out_valid), 64'h00);

    // wrong-destination ready must not pop
    out_ready = 8'h00;
    drive(1'b1, 3'd3, 32'h3333);
    cyc();
    drive(1'b0, 3'd0, 32'd0);
    out_ready = 8'hF7;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("wr_hold_valid", 64'(out_valid), 64'h08);
      chk("wr_hold_data", 64'(demuxout), 64'h3333);
    end
    out_ready = 8'h08;
    cyc();
    chk("wr_popped", 64'(out_valid), 64'h00);

    // streaming, one word per cycle
    out_ready = 8'hFF;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 3'(i % 8), 32'(i));
      cyc();
      chk("stream_ready", 64'(in_ready), 64'd1);
      chk("stream_valid", 64'(out_valid), 64'(8'd1 << (i % 8)));
      chk("stream_data", 64'(demuxout), 64'(i));
    end
    drive(1'b0, 3'd0, 32'd0);
    cyc();
    chk("stream_end", 64'(out_valid), 64'h00);

    // mid-operation reset from FULL
    out_ready = 8'h00;
    drive(1'b1, 3'd6, 32'hA1);
    cyc();
    drive(1'b1, 3'd0, 32'hA2);
    cyc();
    chk("mr_full", 64'(in_ready), 64'd0);
    drive(1'b0, 3'd0, 32'd0);
    rst = 1'b1;
    out_ready = 8'hFF;
    cyc();
    rst = 1'b0;
    chk("mr_valid0", 64'(out_valid), 64'h00);
    chk("mr_ready0", 64'(in_ready), 64'd0);
    cyc();
    chk("mr_no_pulse", 64'(out_valid), 64'h00);
    chk("mr_ready1", 64'(in_ready), 64'd1);
    out_ready = 8'h02;
    drive(1'b1, 3'd1, 32'h55);
    cyc();
    drive(1'b0, 3'd0, 32'd0);
    chk("mr_first_valid", 64'(out_valid), 64'h02);
    chk("mr_first_data", 64'(demuxout), 64'h55);
    cyc();
    chk("mr_first_gone", 64'(out_valid), 64'h00);

    // random traffic, model compare only
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3) != 0, 3'($urandom), 32'($urandom));
      out_ready = 8'($urandom);
      rst = ($urandom_range(0, 149) == 0);
      cyc();
    end
    rst = 1'b0;
    drive(1'b0, 3'd0, 32'd0);
    out_ready = 8'hFF;
    repeat (4) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
